// File: rtl/shift_pkg.sv
// shift_pkg: decode constants, op encodings and issue-entry layout shared by the shift issue stage
package shift_pkg;
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_SRA    = 6'b000011;
    localparam logic [5:0] FN_SLLV   = 6'b000100;
    localparam logic [5:0] FN_SRLV   = 6'b000110;
    localparam logic [5:0] FN_SRAV   = 6'b000111;
    localparam logic [1:0] SOP_SLL   = 2'd0;
    localparam logic [1:0] SOP_SRL   = 2'd1;
    localparam logic [1:0] SOP_SRA   = 2'd2;
    localparam logic [1:0] SOP_ROTR  = 2'd3;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        is_shift;
    } shift_entry_t;
    localparam int ENTRY_W = $bits(shift_entry_t);
    function automatic int entry_w(input int dw);
        return 2 * dw + 3;
    endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry valid/ready elastic buffer; ports clk/rst/flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         m_valid, s_valid, acc, main_free;
    logic [W-1:0] m_data, s_data;
    assign acc       = in_valid && !s_valid;
    // main can take new content when empty or being consumed this cycle
    assign main_free = !m_valid || out_ready;
    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            if (rst) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else if (main_free) begin
            m_valid <= s_valid || acc;
            m_data  <= s_valid ? s_data : acc ? in_data : m_data;
            s_valid <= 1'b0;
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end
endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes R-type shifts into shamt-packed operand A, operand B, op select; 2-entry skid buffer to the shifters
// ports: clk, rst, flush, in_valid/in_ready, instr, rs_val, rt_val, out_valid/out_ready, shift_a, shift_b, shift_op, is_shift
// optional macro SHIFT_ISSUE_ROTR_EN enables ROTR/ROTRV decode (shift_op=3)
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SHAMT_LSB = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] shift_a,
    output logic [DATA_W-1:0] shift_b,
    output logic [1:0]        shift_op,
    output logic              is_shift
);
    localparam int EW = entry_w(DATA_W);
    logic [5:0]        funct;
    logic              rtype, imm_sh, var_sh, is_sh, rot, unused_bits;
    logic [4:0]        shamt;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [EW-1:0]     in_data, out_data;
    assign funct  = instr[5:0];
    assign rtype  = instr[31:26] == OPC_RTYPE;
    assign imm_sh = rtype && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
    assign var_sh = rtype && (funct == FN_SLLV || funct == FN_SRLV || funct == FN_SRAV);
    assign is_sh  = imm_sh || var_sh;
`ifdef SHIFT_ISSUE_ROTR_EN
    assign rot = (funct == FN_SRL && instr[21]) || (funct == FN_SRLV && instr[6]);
`else
    assign rot = 1'b0;
`endif
    assign shamt = imm_sh ? instr[10:6] : rs_val[4:0];
    // funct[1:0] distinguishes the family: 00 left, 10 logical right, 11 arithmetic right
    assign op = !is_sh ? SOP_SLL : rot ? SOP_ROTR : funct[1:0] == 2'b11 ? SOP_SRA : funct[1] ? SOP_SRL : SOP_SLL;
    assign a = is_sh ? DATA_W'(shamt) << SHAMT_LSB : '0;
    assign in_data = {a, rt_val, op, is_sh};
    assign {shift_a, shift_b, shift_op, is_shift} = out_data;
    assign unused_bits = ^{instr[25:11], rs_val[DATA_W-1:5]};
    skid_buf2 #(.W(EW)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: scoreboard bench for shift_issue_stage
module tb_shift_issue_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, is_shift;
    logic [31:0] instr, rs_val, rt_val, shift_a, shift_b;
    logic [1:0]  shift_op;
    int          errors = 0;
    int          checks = 0;
    int          accepted = 0;
    int          emitted = 0;
    logic [66:0] sb[$];
    logic [66:0] held;
    logic        hold_chk = 1'b0;

    shift_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .out_valid(out_valid),
        .out_ready(out_ready), .shift_a(shift_a), .shift_b(shift_b), .shift_op(shift_op),
        .is_shift(is_shift)
    );

    always #5 clk = ~clk;

    function automatic logic [66:0] exp_of(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        logic       sh;
        logic [1:0] op;
        logic [4:0] amt;
        sh = 1'b0; op = 2'd0; amt = 5'd0;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h00: begin sh = 1'b1; op = 2'd0; amt = ins[10:6]; end
                6'h02: begin
                    sh = 1'b1; op = 2'd1; amt = ins[10:6];
`ifdef SHIFT_ISSUE_ROTR_EN
                    if (ins[21]) op = 2'd3;
`endif
                end
                6'h03: begin sh = 1'b1; op = 2'd2; amt = ins[10:6]; end
                6'h04: begin sh = 1'b1; op = 2'd0; amt = rs[4:0]; end
                6'h06: begin
                    sh = 1'b1; op = 2'd1; amt = rs[4:0];
`ifdef SHIFT_ISSUE_ROTR_EN
                    if (ins[6]) op = 2'd3;
`endif
                end
                6'h07: begin sh = 1'b1; op = 2'd2; amt = rs[4:0]; end
                default: ;
            endcase
        end
        return {sh ? {21'd0, amt, 6'd0} : 32'd0, rt, op, sh};
    endfunction

    // one clock: scoreboard bookkeeping at negedge, returns 1 time unit after posedge
    task automatic clock_cycle();
        logic [66:0] got, exp;
        @(negedge clk);
        got = {shift_a, shift_b, shift_op, is_shift};
        if (rst || flush) begin
            sb.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                checks++;
                if (!out_valid || got !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b %h required v=1 %h", out_valid, got, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                emitted++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h required no output", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_entry: got %h required %h", got, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(exp_of(instr, rs_val, rt_val));
                accepted++;
            end
            hold_chk = out_valid && !out_ready;
            held = got;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        instr = ins; rs_val = rs; rt_val = rt; in_valid = 1'b1;
        clock_cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) clock_cycle();
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout: got pending=%0d valid=%0b required 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || shift_a !== 32'd0 || shift_b !== 32'd0 ||
            shift_op !== 2'd0 || is_shift !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b r=%0b a=%h b=%h op=%0d sh=%0b required 0 1 0 0 0 0",
                     out_valid, in_ready, shift_a, shift_b, shift_op, is_shift);
        end
    endtask

    task automatic test_srl();
        out_ready = 1'b1;
        issue(32'h00021082, 32'h0, 32'h80000000);
        checks++;
        if (out_valid !== 1'b1 || shift_op !== 2'd1 || shift_a !== 32'h80 || shift_b !== 32'h80000000 || is_shift !== 1'b1) begin
            errors++;
            $display("FAIL srl: got v=%0b op=%0d a=%h b=%h sh=%0b required 1 1 00000080 80000000 1",
                     out_valid, shift_op, shift_a, shift_b, is_shift);
        end
        drain();
    endtask

    task automatic test_srav();
        issue(32'h00221007, 32'h0000003F, 32'h12345678);
        checks++;
        if (out_valid !== 1'b1 || shift_op !== 2'd2 || shift_a !== 32'h7C0 || is_shift !== 1'b1) begin
            errors++;
            $display("FAIL srav: got v=%0b op=%0d a=%h sh=%0b required 1 2 000007c0 1", out_valid, shift_op, shift_a, is_shift);
        end
        drain();
    endtask

    task automatic test_nonshift();
        issue(32'h00221021, 32'hFFFFFFFF, 32'hCAFEF00D);
        checks++;
        if (out_valid !== 1'b1 || is_shift !== 1'b0 || shift_op !== 2'd0 || shift_a !== 32'd0 || shift_b !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL addu: got v=%0b sh=%0b op=%0d a=%h b=%h required 1 0 0 0 cafef00d",
                     out_valid, is_shift, shift_op, shift_a, shift_b);
        end
        drain();
    endtask

    task automatic test_rotr();
        logic [1:0] exp_op;
`ifdef SHIFT_ISSUE_ROTR_EN
        exp_op = 2'd3;
`else
        exp_op = 2'd1;
`endif
        issue(32'h00200102, 32'h0, 32'h0000000F);
        checks++;
        if (shift_op !== exp_op || shift_a !== 32'h100 || shift_b !== 32'hF) begin
            errors++;
            $display("FAIL rotr: got op=%0d a=%h b=%h required %0d 00000100 0000000f", shift_op, shift_a, shift_b, exp_op);
        end
        issue(32'h002208C6, 32'h00000025, 32'h0000000F);
        checks++;
        if (shift_op !== exp_op || shift_a !== 32'h140) begin
            errors++;
            $display("FAIL rotrv: got op=%0d a=%h required %0d 00000140", shift_op, shift_a, exp_op);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int  acc0, emi0;
        logic took;
        acc0 = accepted; emi0 = emitted;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = {21'd0, 5'(i + 1), 6'h00}; rs_val = 32'd0; rt_val = 32'(100 + i);
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_in_ready%0d: got %0b required %0b", i, in_ready, i < 2);
            end
            clock_cycle();
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || accepted - acc0 != 2) begin
            errors++;
            $display("FAIL bp_full: got r=%0b v=%0b acc=%0d required 0 1 2", in_ready, out_valid, accepted - acc0);
        end
        out_ready = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 10 && !took; i++) begin
            took = in_ready;
            clock_cycle();
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (!took || accepted - acc0 != 3 || emitted - emi0 != 3) begin
            errors++;
            $display("FAIL bp_count: got acc=%0d emit=%0d required 3 3", accepted - acc0, emitted - emi0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00000080; rt_val = 32'h11; clock_cycle();
        instr = 32'h000000C2; rt_val = 32'h22; clock_cycle();
        instr = 32'h00000103; rt_val = 32'h33; flush = 1'b1;
        clock_cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got v=%0b r=%0b required 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1; instr = 32'h00000140; rt_val = 32'h44; flush = 1'b1;
        clock_cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) clock_cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept_dropped: got v=%0b r=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00000080; rt_val = 32'hAAAA5555; clock_cycle();
        instr = 32'h00000004; rs_val = 32'h7; rt_val = 32'h5555AAAA; clock_cycle();
        in_valid = 1'b0; rst = 1'b1;
        clock_cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || shift_a !== 32'd0 || shift_b !== 32'd0 || shift_op !== 2'd0 || is_shift !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b r=%0b a=%h b=%h op=%0d sh=%0b required 0 1 0 0 0 0",
                     out_valid, in_ready, shift_a, shift_b, shift_op, is_shift);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns[8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h2A};
        int emi0;
        out_ready = 1'b1;
        emi0 = emitted;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr = {6'd0, 20'($urandom), fns[i]}; rs_val = $urandom; rt_val = $urandom;
            clock_cycle();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rate%0d: got r=%0b v=%0b required 1 1", i, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (emitted - emi0 != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 8", emitted - emi0);
        end
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 9) < 6;
            instr = {($urandom_range(0, 3) == 0) ? 6'h23 : 6'h00, 20'($urandom), fns[$urandom_range(0, 7)]};
            rs_val = $urandom; rt_val = $urandom;
            clock_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
        for (int i = 0; i < 3; i++) clock_cycle();
        rst = 1'b0;
        test_reset();
        test_srl();
        test_srav();
        test_nonshift();
        test_rotr();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
